// File: rtl/spi_rom_fetch_if.sv
// Fetch-side handshake between the core's fetch stage and the SPI ROM front end.
interface spi_rom_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              req_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic              flush_i;
    logic [31:0]       instr_o;
    logic              instr_valid_o;
    logic              busy_o;

    modport master (
        output req_i, req_addr_i, flush_i,
        input  instr_o, instr_valid_o, busy_o
    );

    modport slave (
        input  req_i, req_addr_i, flush_i,
        output instr_o, instr_valid_o, busy_o
    );
endinterface

// File: rtl/spi_rom_fetch.sv
// Instruction fetch from SPI NOR flash (READ 0x03, mode 0, SCK = clk/2) with a
// one-entry cache and continuous sequential read while chip select stays low.
//
// state | meaning
// IDLE  | no open flash stream, CS high, waiting for a request
// CSHI  | one-cycle CS deassert before restarting a command
// CMD   | shifting out the 0x03 opcode (8 slots)
// ADDR  | shifting out the 24-bit byte address (24 slots)
// DATA  | shifting in 32 instruction bits
// RESP  | instr_valid pulse, cache update
// HOLD  | response done, stream may still be open for a sequential read
module spi_rom_fetch #(
    parameter int ADDR_W     = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rstn,
    spi_rom_fetch_if.slave fetch,
    output logic          spi_cs_n_o,
    output logic          spi_sck_o,
    output logic          spi_mosi_o,
    input  logic          spi_miso_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_CSHI, S_CMD, S_ADDR, S_DATA, S_RESP, S_HOLD
    } state_t;

    state_t state, state_next;

    logic [5:0]            cnt, cnt_load;
    logic [31:0]           tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh, rx_next, rx_word, instr_q, cache_data;
    logic [ADDR_W-1:0]     cur_addr, cache_addr, next_addr;
    logic [23:0]           byte_addr;
    logic                  cache_valid, stream_open;
    logic                  accept, hit, seq, slot_end, term;

    assign byte_addr = 24'({fetch.req_addr_i, 2'b00});
    assign next_addr = cache_addr + ADDR_W'(1);
    assign accept    = (state == S_IDLE || state == S_HOLD) && fetch.req_i && !fetch.flush_i;
    assign hit       = cache_valid && (fetch.req_addr_i == cache_addr);
    // The stream position equals the cached address whenever the stream is open.
    assign seq       = (state == S_HOLD) && stream_open && (cache_addr != '1)
                       && (fetch.req_addr_i == next_addr);
    assign slot_end  = ~cnt[0];
    assign term      = (cnt == 6'd0);
    assign rx_next   = {rx_sh[DATA_WIDTH-2:0], spi_miso_i};
    assign rx_word   = {rx_next[7:0], rx_next[15:8], rx_next[23:16], rx_next[31:24]};

    assign fetch.instr_o = instr_q;

    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (fetch.flush_i) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (accept) state_next = hit ? S_RESP : S_CMD;
                S_CSHI: state_next = S_CMD;
                S_CMD:  if (term) state_next = S_ADDR;
                S_ADDR: if (term) state_next = S_DATA;
                S_DATA: if (term) state_next = S_RESP;
                S_RESP: state_next = S_HOLD;
                S_HOLD: begin
                    if (accept) begin
                        if (hit)              state_next = S_RESP;
                        else if (seq)         state_next = S_DATA;
                        else if (stream_open) state_next = S_CSHI;
                        else                  state_next = S_CMD;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        spi_cs_n_o          = 1'b1;
        spi_sck_o           = 1'b0;
        spi_mosi_o          = 1'b0;
        fetch.instr_valid_o = 1'b0;
        fetch.busy_o        = 1'b0;
        case (state)
            S_CSHI: fetch.busy_o = 1'b1;
            S_CMD, S_ADDR: begin
                spi_cs_n_o   = 1'b0;
                spi_sck_o    = ~cnt[0];
                spi_mosi_o   = tx_sh[31];
                fetch.busy_o = 1'b1;
            end
            S_DATA: begin
                spi_cs_n_o   = 1'b0;
                spi_sck_o    = ~cnt[0];
                fetch.busy_o = 1'b1;
            end
            S_RESP: begin
                spi_cs_n_o          = ~stream_open;
                fetch.instr_valid_o = 1'b1;
                fetch.busy_o        = 1'b1;
            end
            S_HOLD:  spi_cs_n_o = ~stream_open;
            default: spi_cs_n_o = 1'b1;
        endcase
    end

    always_comb begin
        cnt_load = 6'd0;
        case (state_next)
            S_CMD:   cnt_load = 6'd15;
            S_ADDR:  cnt_load = 6'd47;
            S_DATA:  cnt_load = 6'd63;
            default: cnt_load = 6'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            cnt         <= 6'd0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            instr_q     <= '0;
            cur_addr    <= '0;
            cache_addr  <= '0;
            cache_data  <= '0;
            cache_valid <= 1'b0;
            stream_open <= 1'b0;
        end else begin
            if (state_next != state) begin
                cnt <= cnt_load;
            end else if (!term) begin
                cnt <= cnt - 6'd1;
            end

            if (accept) begin
                cur_addr <= fetch.req_addr_i;
                tx_sh    <= {8'h03, byte_addr};
            end else if ((state == S_CMD || state == S_ADDR) && slot_end) begin
                tx_sh <= {tx_sh[30:0], 1'b0};
            end

            if (state == S_DATA && slot_end) begin
                rx_sh <= rx_next;
            end

            if (state_next == S_RESP) begin
                instr_q <= (state == S_DATA) ? rx_word : cache_data;
            end

            // Only a completed response touches the cache, so aborted reads never leak in.
            if (state == S_RESP) begin
                cache_addr  <= cur_addr;
                cache_data  <= instr_q;
                cache_valid <= 1'b1;
            end

            if (state == S_CMD) begin
                stream_open <= 1'b1;
            end else if (state == S_IDLE || state == S_CSHI) begin
                stream_open <= 1'b0;
            end
        end
    end

endmodule

// File: doc/spi_rom_fetch.md
# spi_rom_fetch

Instruction-fetch front end for the RV core: it serves word-address requests from the fetch stage by reading 32-bit instructions from an external SPI NOR flash (READ 0x03, SPI mode 0, SCK = clk/2). It sits directly upstream of the core's instruction port. A one-entry cache answers repeated addresses without SPI traffic, and a continuous-read mode streams sequential words without re-issuing the command. `busy_o` feeds the control unit's hold path, so the pipeline stalls while a word is in flight.

## Interface
- `ADDR_W`, 8: word-address width; legal range 1..22.
- `DATA_WIDTH`, 32: instruction width; fixed at 32.

- `clk`  in  1  single clock domain; all state changes on rising edge.
- `rstn`  in  1  synchronous, active-high reset; one clock, one reset.
- `req_i`  in  1  fetch request; sampled only while `busy_o`=0.
- `req_addr_i`  in  ADDR_W  word address of the request.
- `flush_i`  in  1  abort (jump/redirect); highest priority.
- `instr_o`  out  32  fetched instruction; holds its value between responses.
- `instr_valid_o`  out  1  one-cycle pulse; `instr_o` is valid for `req_addr_i` of the accepted request.
- `busy_o`  out  1  high from the cycle after acceptance through the `instr_valid_o` cycle, inclusive.
- `spi_cs_n_o`  out  1  flash chip select, active low.
- `spi_sck_o`  out  1  SPI clock, idles low.
- `spi_mosi_o`  out  1  command/address, MSB first.
- `spi_miso_i`  in  1  flash data.

## Operation
- States: IDLE, CSHI, CMD, ADDR, DATA, RESP, HOLD.
- Byte address = zero-extended `{req_addr, 2'b00}` to 24 bits.
- Bit slot = 2 clk cycles:
  - Slot cycle 0: `spi_sck_o`=0; MOSI updates.
  - Slot cycle 1: `spi_sck_o`=1; MISO sampled at the clock edge ending this cycle.
- CMD sends 0x03 (8 slots). ADDR sends 24 slots. DATA receives 32 slots.
- Received bytes are little-endian: first byte → `instr_o[7:0]`; within a byte, the first bit is the MSB.
- RESP: `instr_o` loads, `instr_valid_o`=1, cache loads {addr, data, valid}, next state HOLD. `spi_cs_n_o` stays low; SCK stays low.
- Request accepted in IDLE or HOLD, in priority order:
  - Cache hit (valid entry and addr equals the cached addr): go to RESP with the cached data, no SPI activity. From HOLD, CS stays low.
  - HOLD and addr = last+1 with last ≠ all-ones: go to DATA (continuous read).
  - From IDLE: go to CMD with `spi_cs_n_o` low.
  - From HOLD, any other address: go to CSHI (`spi_cs_n_o`=1 for exactly one cycle), then CMD.
- Wrap: a last address of 2^ADDR_W−1 never continues; the flash would return byte address 4·2^ADDR_W, not 0. Address 0 reissues the command.
- Cache is updated only in RESP; an aborted read never corrupts it.
- `flush_i`:
  - Next cycle: state IDLE, `spi_cs_n_o`=1, `spi_sck_o`=0, `busy_o`=0, no `instr_valid_o`.
  - A `req_i` in the same cycle is ignored.
  - A flush asserted in the RESP cycle still lets that pulse out; the cache is kept.
- Reset values: `spi_cs_n_o`=1, `spi_sck_o`=0, `spi_mosi_o`=0, `instr_o`=0, `instr_valid_o`=0, `busy_o`=0, cache invalid, state IDLE. Reset mid-transfer: same values on the next cycle; the transfer is dropped.

## Timing
Request accepted at cycle t.
- IDLE miss:
  - CMD t+1..t+16, ADDR t+17..t+64, DATA t+65..t+128.
  - `instr_valid_o` at t+129; `busy_o` t+1..t+129.
- HOLD non-sequential miss: CSHI t+1, CMD t+2..t+17, `instr_valid_o` at t+130.
- HOLD sequential: DATA t+1..t+64, `instr_valid_o` at t+65.
- Cache hit: `instr_valid_o` at t+1; `busy_o` high at t+1 only.
- Earliest next acceptance: the cycle after `instr_valid_o`.
- `spi_sck_o` toggles only in CMD/ADDR/DATA, and never while `spi_cs_n_o`=1.

## Test plan
- Reset, then `req_addr_i`=0x04 from IDLE; flash model holds bytes 13 05 10 00 at byte 0x10:
  - MOSI carries 0x03, then 0x000010.
  - `instr_o`=0x00100513, `instr_valid_o` at t+129, CS stays low afterwards.
- After the above, request 0x05 (bytes 93 05 20 00 at 0x14): no command sent, `instr_o`=0x00200593 at t+65.
- Request 0x05 again: `instr_o`=0x00200593 at t+1, zero SCK edges.
- Sequence 0x05 → 0x20: CS high exactly one cycle, full command with address 0x000080, valid at t+130.
- With ADDR_W=8, sequence 0xFF → 0x00: command reissued with address 0x000000, not continued.
- `flush_i` during ADDR bit 10, then a request to the same address:
  - Flush: CS high next cycle, no valid pulse.
  - Re-request: cache miss, full 129-cycle read.
  - `rstn` pulse mid-DATA gives all reset values on the next cycle.
